// File: rtl/alu_seq_n.sv
// ---------------------------------------------------------------------------
// alu_seq_n
// WIDTH-bit registered ALU with a valid/ready handshake. Single-cycle ops
// (AND, OR, XOR, ADD, SUB, SLT, NOR) write their result on the accept edge.
// MUL is an unsigned shift-add multiplier that retires one bit of B per
// cycle. Only one operation is in flight at a time.
//
// Ports
//   Clock     rising-edge clock
//   Reset     synchronous, active-high reset (priority over all inputs)
//   Start     request, accepted on the edge where Start && InReady
//   A, B      operands, sampled on accept
//   Op        000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 SLT,
//             110 MUL, 111 NOR
//   InReady   high only in IDLE
//   OutValid  high only in DONE
//   OutReady  consumer accepts the result when OutValid && OutReady
//   Result    registered result
//   CarryOut  ADD carry; SUB/SLT no-borrow; MUL high half nonzero
//   Overflow  signed overflow for ADD/SUB/SLT
//   Zero      Result == 0
//
// CNT_W must satisfy 2**CNT_W > WIDTH so the iteration counter can reach
// WIDTH-1.
// ---------------------------------------------------------------------------
module alu_seq_n #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op,
    output logic             InReady,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t state_reg;
    state_t state_next;

    // FSM control strobes
    logic accept;
    logic load_alu;
    logic load_mul;
    logic mul_step;
    logic mul_last;

    // Result / flag registers
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;
    logic             ovf_reg;
    logic             zero_reg;

    // Multiplier state
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [2*WIDTH-1:0] acc_next;

    // ------------------------------------------------------------------
    // Bitwise logic unit, one slice per bit
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] and_bits;
    logic [WIDTH-1:0] or_bits;
    logic [WIDTH-1:0] xor_bits;
    logic [WIDTH-1:0] nor_bits;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_logic_slice
            assign and_bits[gi] = A[gi] & B[gi];
            assign or_bits[gi]  = A[gi] | B[gi];
            assign xor_bits[gi] = A[gi] ^ B[gi];
            assign nor_bits[gi] = ~(A[gi] | B[gi]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Shared adder: ADD uses B, SUB/SLT use ~B with carry-in 1
    // ------------------------------------------------------------------
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic             add_ovf;
    logic             slt_bit;

    assign is_sub  = (Op == OP_SUB) || (Op == OP_SLT);
    assign b_eff   = is_sub ? ~B : B;
    assign sum_ext = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    // Overflow when both adder inputs share a sign that the sum does not
    assign add_ovf = (A[WIDTH-1] == b_eff[WIDTH-1]) &&
                     (sum_ext[WIDTH-1] != A[WIDTH-1]);
    // Signed less-than: sign of the difference, corrected by overflow
    assign slt_bit = sum_ext[WIDTH-1] ^ add_ovf;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (Op)
            OP_AND: alu_res = and_bits;
            OP_OR:  alu_res = or_bits;
            OP_XOR: alu_res = xor_bits;
            OP_NOR: alu_res = nor_bits;
            OP_ADD, OP_SUB: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = add_ovf;
            end
            OP_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
                alu_c   = sum_ext[WIDTH];
                alu_v   = add_ovf;
            end
            default: begin
                // MUL results come from the multiplier path
                alu_res = '0;
            end
        endcase
    end

    // Partial-product accumulate for the current multiplier bit
    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : {(2*WIDTH){1'b0}});

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        InReady    = 1'b0;
        OutValid   = 1'b0;
        accept     = 1'b0;
        load_alu   = 1'b0;
        load_mul   = 1'b0;
        mul_step   = 1'b0;
        mul_last   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                InReady = 1'b1;
                accept  = Start;
                if (Start) begin
                    if (Op == OP_MUL) begin
                        load_mul   = 1'b1;
                        state_next = S_MUL;
                    end else begin
                        load_alu   = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            S_MUL: begin
                mul_step = 1'b1;
                if (count_reg == CNT_W'(WIDTH - 1)) begin
                    mul_last   = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                OutValid = 1'b1;
                if (OutReady) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            result_reg <= '0;
            carry_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
            zero_reg   <= 1'b1;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (load_alu) begin
                result_reg <= alu_res;
                carry_reg  <= alu_c;
                ovf_reg    <= alu_v;
                zero_reg   <= (alu_res == '0);
            end
            if (load_mul) begin
                acc_reg    <= '0;
                mcand_reg  <= {{WIDTH{1'b0}}, A};
                mplier_reg <= B;
                count_reg  <= '0;
            end
            if (mul_step) begin
                acc_reg    <= acc_next;
                mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
                mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
                count_reg  <= count_reg + CNT_W'(1);
                // The last step writes straight from the final accumulator
                // so the result is ready the cycle DONE is entered.
                if (mul_last) begin
                    result_reg <= acc_next[WIDTH-1:0];
                    carry_reg  <= |acc_next[2*WIDTH-1:WIDTH];
                    ovf_reg    <= 1'b0;
                    zero_reg   <= (acc_next[WIDTH-1:0] == '0);
                end
            end
        end
    end

    assign Result   = result_reg;
    assign CarryOut = carry_reg;
    assign Overflow = ovf_reg;
    assign Zero     = zero_reg;

    // accept is kept for readability of the IDLE branch
    logic unused_ok;
    assign unused_ok = accept;

endmodule

// File: tb/tb_alu_seq_n.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_n
// Self-checking bench for alu_seq_n (WIDTH=16): directed cases, backpressure,
// reset abort, then randomized ops against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_seq_n;

    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    op;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          overflow;
    logic          zero;

    int n_vec;
    int n_bad;

    alu_seq_n #(.WIDTH(W), .CNT_W(5)) dut (
        .Clock    (clk),
        .Reset    (rst),
        .Start    (start),
        .A        (a),
        .B        (b),
        .Op       (op),
        .InReady  (in_ready),
        .OutValid (out_valid),
        .OutReady (out_ready),
        .Result   (result),
        .CarryOut (carry_out),
        .Overflow (overflow),
        .Zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model from the arithmetic definition of each op
    task automatic ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                             input logic [2:0] rop, output logic [W-1:0] r,
                             output logic c, output logic v);
        int sa;
        int sb;
        int s;
        logic [31:0] p;
        sa = int'($signed(ra));
        sb = int'($signed(rb));
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (rop)
            3'd0: r = ra & rb;
            3'd1: r = ra | rb;
            3'd2: r = ra ^ rb;
            3'd3: begin
                p = 32'(ra) + 32'(rb);
                r = p[15:0];
                c = (p > 32'd65535);
                s = sa + sb;
                v = (s > 32767) || (s < -32768);
            end
            3'd4, 3'd5: begin
                p = 32'(ra) - 32'(rb);
                r = (rop == 3'd4) ? p[15:0] : ((sa < sb) ? 16'd1 : 16'd0);
                c = (ra >= rb);
                s = sa - sb;
                v = (s > 32767) || (s < -32768);
            end
            3'd6: begin
                p = 32'(ra) * 32'(rb);
                r = p[15:0];
                c = (p[31:16] != 16'd0);
            end
            default: r = ~(ra | rb);
        endcase
    endtask

    // One complete transaction. Entered and left just after a falling edge.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [2:0] top, input int stall);
        logic [W-1:0] er;
        logic ec;
        logic ev;
        int lat;
        int exp_lat;
        ref_model(ta, tb, top, er, ec, ev);
        exp_lat = (top == 3'd6) ? W + 1 : 1;
        a = ta;
        b = tb;
        op = top;
        start = 1'b1;
        out_ready = 1'b0;
        check_val("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        op = 3'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat < exp_lat) begin
                a = W'($urandom);
                b = W'($urandom);
            end
        end while (!out_valid && lat < 40);
        check_val("latency", 32'(lat), 32'(exp_lat));
        check_val("result", 32'(result), 32'(er));
        check_val("carry", 32'(carry_out), 32'(ec));
        check_val("overflow", 32'(overflow), 32'(ev));
        check_val("zero", 32'(zero), 32'(er == '0));
        check_val("in_ready_done", 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            start = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            op = 3'($urandom);
            @(negedge clk);
            check_val("hold_valid", 32'(out_valid), 32'd1);
            check_val("hold_result", {15'd0, carry_out, result},
                      {15'd0, ec, er});
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_val("back_to_idle", {30'd0, in_ready, out_valid}, 32'd2);
        $display("op=%0d a=%h b=%h res=%h c=%0b v=%0b z=%0b lat=%0d stall=%0d",
                 top, ta, tb, result, carry_out, overflow, zero, lat, stall);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_state", {27'd0, in_ready, out_valid, carry_out, overflow, zero},
                  32'b10001);
        check_val("rst_result", 32'(result), 32'd0);

        // Directed cases
        do_op(16'h7FFF, 16'h0001, 3'd3, 0);
        check_val("add_ovf_flag", 32'(overflow), 32'd1);
        do_op(16'h0005, 16'h0005, 3'd4, 1);
        do_op(16'h0000, 16'h0001, 3'd4, 0);
        do_op(16'hFFFF, 16'h0001, 3'd5, 0);
        do_op(16'h0001, 16'hFFFF, 3'd5, 0);
        do_op(16'h0100, 16'h0100, 3'd6, 0);
        do_op(16'h00FF, 16'h0003, 3'd6, 2);
        do_op(16'h1234, 16'h0F0F, 3'd7, 0);
        do_op(16'hA5A5, 16'h5A5A, 3'd2, 0);
        // Backpressure with Start pulses during DONE
        do_op(16'h1111, 16'h2222, 3'd3, 5);
        do_op(16'hFFFF, 16'hFFFF, 3'd0, 0);

        // Reset in the middle of a multiply
        a = 16'h0003;
        b = 16'h0005;
        op = 3'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("abort_state", {29'd0, in_ready, out_valid, zero}, 32'b101);
        check_val("abort_result", 32'(result), 32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < W + 4; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check_val("abort_no_valid", 32'(seen), 32'd0);
        end

        // Randomized ops with random consumer stalls
        for (int n = 0; n < 10000; n++) begin
            do_op(W'($urandom), W'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
